// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   STARVE_MAX_DEF   : default CPU grants allowed back-to-back while a burst waits
//   DMA_MAX_LEN_DEF  : default longest accepted burst, in words
//   STARVE_W         : width of the CPU-grant run counter
package mem_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int STARVE_MAX_DEF  = 4;
   localparam int DMA_MAX_LEN_DEF = 16;
   localparam int STARVE_W        = 8;

endpackage

// File: rtl/dma_addr_gen.sv
// Burst address/length tracker for the DMA side of the arbiter.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   capture               : load a new burst (base, length, direction)
//   advance               : one DMA beat granted this cycle
//   dma_addr/len/write    : burst request fields
//   addr_q, rem_q, dir_q  : current beat address, words left, direction
//   last_beat             : current beat is the final one
module dma_addr_gen
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        capture,
   input  logic        advance,
   input  logic [31:0] dma_addr,
   input  logic [4:0]  dma_len,
   input  logic        dma_write,
   output logic [31:0] addr_q,
   output logic [4:0]  rem_q,
   output logic        dir_q,
   output logic        last_beat
);

   // rem_q is a down-counter of words still owed; the final beat is its
   // terminal count of one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q <= '0;
         rem_q  <= '0;
         dir_q  <= 1'b0;
      end else if (capture) begin
         addr_q <= {dma_addr[31:2], 2'b00};
         rem_q  <= dma_len;
         dir_q  <= dma_write;
      end else if (advance) begin
         addr_q <= addr_q + 32'd4;
         rem_q  <= rem_q - 5'd1;
      end
   end

   assign last_beat = (rem_q == 5'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the CPU memory stage and a DMA
// burst engine. The CPU owns the port unless a burst is running; during a
// burst the DMA wins whenever the CPU is quiet, and is forced in after
// STARVE_MAX back-to-back CPU grants.
// Ports:
//   clk, reset                      : clock, synchronous active-low reset
//   MemReqM/MemWriteM/beM/ALUresultM/WriteDataM : CPU memory-stage access
//   StallM, ReadDataCpu             : CPU hold request, CPU load data
//   dma_start/write/addr/len/wdata  : burst request and write data
//   dma_busy/wready/rvalid/rdata/done : burst status and read data
//   MemWriteD/beD/AddrD/WriteDataD/ReadDataD : data-memory port
//
// state | meaning
// IDLE  | CPU owns dmem, waiting for a valid dma_start
// BURST | burst in progress, DMA/CPU share dmem with starvation limit
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX  = STARVE_MAX_DEF,
   parameter int DMA_MAX_LEN = DMA_MAX_LEN_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [3:0]  beM,
   input  logic [31:0] ALUresultM,
   input  logic [31:0] WriteDataM,
   output logic        StallM,
   output logic [31:0] ReadDataCpu,
   input  logic        dma_start,
   input  logic        dma_write,
   input  logic [31:0] dma_addr,
   input  logic [4:0]  dma_len,
   input  logic [31:0] dma_wdata,
   output logic        dma_busy,
   output logic        dma_wready,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        dma_done,
   output logic        MemWriteD,
   output logic [3:0]  beD,
   output logic [31:0] AddrD,
   output logic [31:0] WriteDataD,
   input  logic [31:0] ReadDataD
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam logic [31:0]         MAX_LEN    = 32'(DMA_MAX_LEN);

   arb_state_e          state_q;
   logic [STARVE_W-1:0] starve_q;
   logic [31:0]         addr_q;
   logic [4:0]          rem_q;
   logic                dir_q;
   logic                last_beat;
   logic                in_burst;
   logic                start_ok;
   logic                dma_grant;

   // Qualifying with reset keeps every DMA strobe and the stall low while
   // reset is asserted, so an aborted burst never moves another word.
   assign in_burst  = (state_q == BURST) && reset;
   assign start_ok  = (state_q == IDLE) && dma_start && (dma_len != 5'd0)
                      && ({27'd0, dma_len} <= MAX_LEN);
   assign dma_grant = in_burst && (!MemReqM || (starve_q == STARVE_LIM));

   dma_addr_gen u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .capture   (start_ok),
      .advance   (dma_grant),
      .dma_addr  (dma_addr),
      .dma_len   (dma_len),
      .dma_write (dma_write),
      .addr_q    (addr_q),
      .rem_q     (rem_q),
      .dir_q     (dir_q),
      .last_beat (last_beat)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               starve_q <= '0;
               if (start_ok) state_q <= BURST;
            end
            BURST: begin
               if (dma_grant) begin
                  starve_q <= '0;
                  if (last_beat) state_q <= IDLE;
               end else begin
                  starve_q <= starve_q + 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               starve_q <= '0;
            end
         endcase
      end
   end

   always_comb begin
      AddrD      = ALUresultM;
      beD        = beM;
      WriteDataD = WriteDataM;
      MemWriteD  = MemReqM & MemWriteM;
      if (dma_grant) begin
         AddrD      = addr_q;
         beD        = 4'b1111;
         WriteDataD = dma_wdata;
         MemWriteD  = dir_q;
      end
   end

   assign StallM      = MemReqM & dma_grant;
   assign ReadDataCpu = ReadDataD;
   assign dma_busy    = in_burst;
   assign dma_wready  = dma_grant & dir_q;
   assign dma_rvalid  = dma_grant & ~dir_q;
   assign dma_rdata   = ReadDataD;
   assign dma_done    = dma_grant & last_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int SMAX = 4;
   localparam int LMAX = 16;

   logic        clk, reset;
   logic        MemReqM, MemWriteM;
   logic [3:0]  beM;
   logic [31:0] ALUresultM, WriteDataM;
   logic        StallM;
   logic [31:0] ReadDataCpu;
   logic        dma_start, dma_write;
   logic [31:0] dma_addr;
   logic [4:0]  dma_len;
   logic [31:0] dma_wdata;
   logic        dma_busy, dma_wready, dma_rvalid, dma_done;
   logic [31:0] dma_rdata;
   logic        MemWriteD;
   logic [3:0]  beD;
   logic [31:0] AddrD, WriteDataD, ReadDataD;

   mem_arbiter #(.STARVE_MAX(SMAX), .DMA_MAX_LEN(LMAX)) dut (
      .clk(clk), .reset(reset),
      .MemReqM(MemReqM), .MemWriteM(MemWriteM), .beM(beM),
      .ALUresultM(ALUresultM), .WriteDataM(WriteDataM),
      .StallM(StallM), .ReadDataCpu(ReadDataCpu),
      .dma_start(dma_start), .dma_write(dma_write), .dma_addr(dma_addr),
      .dma_len(dma_len), .dma_wdata(dma_wdata),
      .dma_busy(dma_busy), .dma_wready(dma_wready), .dma_rvalid(dma_rvalid),
      .dma_rdata(dma_rdata), .dma_done(dma_done),
      .MemWriteD(MemWriteD), .beD(beD), .AddrD(AddrD),
      .WriteDataD(WriteDataD), .ReadDataD(ReadDataD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_pat(input int i);
      return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   // 64-word data memory, aliased on address bits [7:2]
   logic [31:0] mem [64];
   logic        mem_load;
   assign ReadDataD = mem[AddrD[7:2]];

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_pat(i);
      end else if (MemWriteD) begin
         for (int b = 0; b < 4; b++)
            if (beD[b]) mem[AddrD[7:2]][8*b +: 8] <= WriteDataD[8*b +: 8];
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      MemReqM = 0; MemWriteM = 0; beM = 4'h0; ALUresultM = 32'h100; WriteDataM = 0;
      dma_start = 0; dma_write = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
   endtask

   typedef struct {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        exp_mw;
      logic [3:0]  exp_be;
   } idle_vec_t;

   idle_vec_t tv [5];

   // behavioural reference state for the random phase
   logic [31:0] ref_mem [64];
   bit          m_busy;
   logic [31:0] m_addr;
   int          m_left, m_run;
   bit          m_dir;

   initial begin
      int done_cyc;
      int idx;
      bit dma_turn;

      tv[0] = '{1'b1, 1'b1, 4'h3, 32'h104, 32'hDEAD_BEEF, 1'b1, 4'h3};
      tv[1] = '{1'b1, 1'b0, 4'hF, 32'h108, 32'h1234_5678, 1'b0, 4'hF};
      tv[2] = '{1'b0, 1'b1, 4'hF, 32'h10C, 32'h0BAD_F00D, 1'b0, 4'hF};
      tv[3] = '{1'b0, 1'b0, 4'h1, 32'h10C, 32'h5555_AAAA, 1'b0, 4'h1};
      tv[4] = '{1'b1, 1'b1, 4'h8, 32'h110, 32'h8000_0001, 1'b1, 4'h8};

      // reset and memory preload
      idle_in();
      reset = 0; mem_load = 1;
      tick(); tick();
      mem_load = 0;
      #3;
      chk("rst_busy",   32'(dma_busy),   0);
      chk("rst_stall",  32'(StallM),     0);
      chk("rst_done",   32'(dma_done),   0);
      chk("rst_wready", 32'(dma_wready), 0);
      chk("rst_rvalid", 32'(dma_rvalid), 0);
      tick();
      reset = 1;

      // CPU ownership while idle
      for (int i = 0; i < 5; i++) begin
         tick();
         MemReqM = tv[i].req; MemWriteM = tv[i].we; beM = tv[i].be;
         ALUresultM = tv[i].addr; WriteDataM = tv[i].wd;
         #3;
         chk($sformatf("idle%0d_mw", i),    32'(MemWriteD), 32'(tv[i].exp_mw));
         chk($sformatf("idle%0d_be", i),    32'(beD),       32'(tv[i].exp_be));
         chk($sformatf("idle%0d_addr", i),  AddrD,          tv[i].addr);
         chk($sformatf("idle%0d_wd", i),    WriteDataD,     tv[i].wd);
         chk($sformatf("idle%0d_stall", i), 32'(StallM),    0);
      end

      // write burst, 3 words at 0x100, CPU quiet
      tick(); idle_in();
      dma_start = 1; dma_write = 1; dma_addr = 32'h100; dma_len = 5'd3;
      #3;
      chk("wr3_busy_pre", 32'(dma_busy), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         dma_start = 0; dma_wdata = 32'h1111_0000 + 32'(k);
         #3;
         chk($sformatf("wr3_addr%0d", k),   AddrD,            32'h100 + 32'(4*k));
         chk($sformatf("wr3_mw%0d", k),     32'(MemWriteD),   1);
         chk($sformatf("wr3_be%0d", k),     32'(beD),         32'hF);
         chk($sformatf("wr3_wready%0d", k), 32'(dma_wready),  1);
         chk($sformatf("wr3_done%0d", k),   32'(dma_done),    32'(k == 2));
         chk($sformatf("wr3_busy%0d", k),   32'(dma_busy),    1);
      end
      tick();
      #3;
      chk("wr3_busy_post",   32'(dma_busy),   0);
      chk("wr3_wready_post", 32'(dma_wready), 0);

      // rejected starts: len 0 and len > max
      tick(); idle_in();
      dma_start = 1; dma_addr = 32'h200; dma_len = 5'd0;
      tick(); dma_start = 0;
      #3 chk("len0_ignored", 32'(dma_busy), 0);
      tick(); dma_start = 1; dma_len = 5'd17;
      tick(); dma_start = 0;
      #3 chk("len17_ignored", 32'(dma_busy), 0);

      // read burst of 2 from unaligned base, second start while busy
      tick();
      dma_start = 1; dma_write = 0; dma_addr = 32'h101; dma_len = 5'd2;
      tick();
      dma_addr = 32'h200; dma_len = 5'd5; dma_write = 1;
      #3;
      chk("rd2_addr0",  AddrD,           32'h100);
      chk("rd2_rvalid", 32'(dma_rvalid), 1);
      chk("rd2_data0",  dma_rdata,       32'h1111_0000);
      chk("rd2_mw",     32'(MemWriteD),  0);
      tick();
      #3;
      chk("rd2_addr1", AddrD,         32'h104);
      chk("rd2_data1", dma_rdata,     32'h1111_0001);
      chk("rd2_done",  32'(dma_done), 1);
      tick(); dma_start = 0;
      #3 chk("busy_start_ignored", 32'(dma_busy), 0);

      // read burst of 4 against a CPU that never lets go
      tick(); idle_in();
      dma_start = 1; dma_write = 0; dma_addr = 32'h100; dma_len = 5'd4;
      tick();
      dma_start = 0; MemReqM = 1; MemWriteM = 0; beM = 4'hF; ALUresultM = 32'h108;
      done_cyc = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) tick();
         #3;
         chk($sformatf("starve_stall_c%0d", c), 32'(StallM), 32'((c % 5) == 0));
         if (!StallM) chk($sformatf("starve_cpu_c%0d", c), ReadDataCpu, 32'h1111_0002);
         if (dma_done) begin
            done_cyc = c;
            break;
         end
      end
      chk("starve_done_cycle", 32'(done_cyc), 20);
      tick(); idle_in();
      #3 chk("starve_busy_post", 32'(dma_busy), 0);

      // address wrap
      tick();
      dma_start = 1; dma_write = 1; dma_addr = 32'hFFFF_FFFC; dma_len = 5'd2;
      tick(); dma_start = 0;
      #3 chk("wrap_addr0", AddrD, 32'hFFFF_FFFC);
      tick();
      #3;
      chk("wrap_addr1", AddrD,         32'h0000_0000);
      chk("wrap_done",  32'(dma_done), 1);

      // reset during beat 2 of a 5-word burst
      tick(); idle_in();
      dma_start = 1; dma_write = 1; dma_addr = 32'h120; dma_len = 5'd5; dma_wdata = 32'h7777_0000;
      tick(); dma_start = 0;
      #3 chk("abort_beat1", AddrD, 32'h120);
      tick(); reset = 0;
      #3;
      chk("abort_done",  32'(dma_done), 0);
      chk("abort_busy",  32'(dma_busy), 0);
      chk("abort_stall", 32'(StallM),   0);
      tick(); reset = 1;
      MemReqM = 1; MemWriteM = 1; beM = 4'hF; ALUresultM = 32'h130; WriteDataM = 32'hCAFE_0001;
      #3;
      chk("abort_idle_busy", 32'(dma_busy),  0);
      chk("abort_cpu_stall", 32'(StallM),    0);
      chk("abort_cpu_mw",    32'(MemWriteD), 1);
      chk("abort_cpu_addr",  AddrD,          32'h130);
      tick(); MemWriteM = 0; ALUresultM = 32'h130;
      #3 chk("abort_cpu_load", ReadDataCpu, 32'hCAFE_0001);
      tick(); ALUresultM = 32'h124;
      #3 chk("abort_beat2_untouched", ReadDataCpu, init_pat(9));

      // randomized traffic against the reference model
      tick(); idle_in();
      reset = 0; mem_load = 1;
      tick();
      mem_load = 0; reset = 1;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_pat(i);
      m_busy = 0; m_addr = 0; m_left = 0; m_run = 0; m_dir = 0;

      for (int n = 0; n < 1500; n++) begin
         tick();
         reset      = ($urandom_range(0, 149) != 0);
         MemReqM    = ($urandom_range(0, 3) != 0);
         MemWriteM  = $urandom_range(0, 1);
         beM        = 4'($urandom_range(1, 15));
         ALUresultM = 32'h100 + 32'(4 * $urandom_range(0, 15));
         WriteDataM = $urandom;
         dma_start  = ($urandom_range(0, 5) == 0);
         dma_write  = $urandom_range(0, 1);
         dma_addr   = 32'h100 + 32'($urandom_range(0, 63));
         dma_len    = 5'($urandom_range(0, 20));
         dma_wdata  = $urandom;
         #3;

         dma_turn = m_busy && reset && (!MemReqM || m_run == SMAX);
         chk("rnd_busy", 32'(dma_busy), 32'(m_busy && reset));
         if (dma_turn) begin
            idx = int'(m_addr[7:2]);
            chk("rnd_dma_addr",   AddrD,           m_addr);
            chk("rnd_dma_stall",  32'(StallM),     32'(MemReqM));
            chk("rnd_dma_mw",     32'(MemWriteD),  32'(m_dir));
            chk("rnd_dma_wready", 32'(dma_wready), 32'(m_dir));
            chk("rnd_dma_rvalid", 32'(dma_rvalid), 32'(!m_dir));
            chk("rnd_dma_done",   32'(dma_done),   32'(m_left == 1));
            if (m_dir) begin
               chk("rnd_dma_wdata", WriteDataD, dma_wdata);
               ref_mem[idx] = dma_wdata;
            end else begin
               chk("rnd_dma_rdata", dma_rdata, ref_mem[idx]);
            end
         end else begin
            idx = int'(ALUresultM[7:2]);
            chk("rnd_cpu_addr",  AddrD,       ALUresultM);
            chk("rnd_cpu_stall", 32'(StallM), 0);
            chk("rnd_cpu_mw",    32'(MemWriteD), 32'(MemReqM && MemWriteM));
            chk("rnd_cpu_dmaflags", {29'd0, dma_wready, dma_rvalid, dma_done}, 0);
            if (MemReqM && !MemWriteM) chk("rnd_cpu_load", ReadDataCpu, ref_mem[idx]);
            if (MemReqM && MemWriteM)
               for (int b = 0; b < 4; b++)
                  if (beM[b]) ref_mem[idx][8*b +: 8] = WriteDataM[8*b +: 8];
         end

         if (!reset) begin
            m_busy = 0; m_run = 0;
         end else if (m_busy) begin
            if (dma_turn) begin
               m_addr = m_addr + 32'd4;
               m_left = m_left - 1;
               m_run  = 0;
               if (m_left == 0) m_busy = 0;
            end else begin
               m_run = m_run + 1;
            end
         end else if (dma_start && dma_len >= 1 && int'(dma_len) <= LMAX) begin
            m_busy = 1;
            m_addr = {dma_addr[31:2], 2'b00};
            m_left = int'(dma_len);
            m_dir  = dma_write;
            m_run  = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, max consecutive CPU grants while a DMA burst is pending.
REQ-002 Parameter DMA_MAX_LEN, default 16, max words per DMA burst.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 MemReqM  in  1  memory stage requests dmem (load or store).
REQ-006 MemWriteM  in  1  memory stage access is a store.
REQ-007 beM  in  4  memory stage byte enables.
REQ-008 ALUresultM  in  32  memory stage byte address.
REQ-009 WriteDataM  in  32  memory stage store data.
REQ-010 StallM  out  1  memory stage access not performed this cycle; pipeline holds M.
REQ-011 ReadDataCpu  out  32  load data to memory stage.
REQ-012 dma_start  in  1  DMA burst request, sampled only when dma_busy=0.
REQ-013 dma_write  in  1  burst direction: 1 write to dmem, 0 read from dmem.
REQ-014 dma_addr  in  32  burst base byte address.
REQ-015 dma_len  in  5  burst length in words.
REQ-016 dma_wdata  in  32  current write-burst word.
REQ-017 dma_busy  out  1  burst in progress.
REQ-018 dma_wready  out  1  dma_wdata consumed this cycle.
REQ-019 dma_rvalid  out  1  dma_rdata valid this cycle.
REQ-020 dma_rdata  out  32  read-burst word.
REQ-021 dma_done  out  1  one-cycle pulse on final beat.
REQ-022 MemWriteD, beD[3:0], AddrD[31:0], WriteDataD[31:0]  out  dmem port; ReadDataD[31:0]  in  asynchronous dmem read data.

Function
REQ-023 FSM states IDLE, BURST; dmem read is combinational, dmem write commits on clk edge.
REQ-024 IDLE: CPU owns dmem; AddrD=ALUresultM, beD=beM, WriteDataD=WriteDataM, MemWriteD=MemReqM&MemWriteM, StallM=0.
REQ-025 IDLE & dma_start & 1<=dma_len<=DMA_MAX_LEN: capture addr_q={dma_addr[31:2],2'b00}, rem_q=dma_len, dir_q=dma_write; next state BURST.
REQ-026 dma_start with dma_len=0 or >DMA_MAX_LEN is ignored; dma_start while dma_busy=1 is ignored.
REQ-027 dma_busy=1 exactly while state=BURST.
REQ-028 BURST grant: DMA if MemReqM=0 or starve_q==STARVE_MAX, else CPU.
REQ-029 starve_q increments on each CPU grant in BURST, clears on DMA grant and in IDLE.
REQ-030 DMA grant: AddrD=addr_q, beD=4'b1111, MemWriteD=dir_q, WriteDataD=dma_wdata; dma_wready=dir_q; dma_rvalid=!dir_q with dma_rdata=ReadDataD.
REQ-031 DMA grant: addr_q+=4 (wrap modulo 2^32), rem_q-=1; if rem_q==1, dma_done=1 same cycle and next state IDLE.
REQ-032 StallM=MemReqM & DMA grant; on StallM=1 MemWriteD reflects DMA only (no CPU store).
REQ-033 ReadDataCpu=ReadDataD always; valid only when MemReqM=1 & StallM=0.
REQ-034 dma_wready, dma_rvalid, dma_done are 0 in all non-DMA-grant cycles.

Reset
REQ-035 reset=0 at clk edge: state=IDLE, addr_q=0, rem_q=0, dir_q=0, starve_q=0.
REQ-036 Outputs during/after reset: dma_busy=0, dma_done=0, dma_wready=0, dma_rvalid=0, StallM=0.
REQ-037 Reset mid-burst aborts without dma_done; remaining words not transferred.

Structure
REQ-038 Package mem_arb_pkg holds state enum (IDLE, BURST), STARVE_MAX and DMA_MAX_LEN defaults.
REQ-039 One sub-module dma_addr_gen holds addr_q/rem_q/dir_q, capture and increment logic, last-beat flag.

Verification
REQ-040 DMA write, addr 0x100, len 3, MemReqM=0 -> beats at 0x100/0x104/0x108 on 3 consecutive cycles, dma_done on 3rd, busy clears next cycle.
REQ-041 DMA read len 4 with MemReqM=1 continuously, STARVE_MAX=4 -> 4 CPU grants, 1 DMA beat (StallM=1), repeated; done after 20 cycles.
REQ-042 dma_addr=0xFFFFFFFC, len 2 -> AddrD 0xFFFFFFFC then 0x00000000.
REQ-043 dma_start with len 0, and second dma_start during busy -> both ignored, no state change.
REQ-044 reset=0 on beat 2 of 5 -> IDLE next cycle, dma_busy=0, no dma_done, CPU store passes unstalled.
